// File: rtl/rom_arbiter_if.sv
// Request/ROM/response bundle shared between the ROM arbiter (slave) and its
// requesters plus ROM model (master).
interface rom_arbiter_if #(
  parameter int NREQ  = 3,
  parameter int WIDTH = 8,
  parameter int DEPTH = 256
);
  localparam int ADDRW = $clog2(DEPTH);

  logic [NREQ-1:0]       req_valid;
  logic [NREQ*ADDRW-1:0] req_addr;
  logic [NREQ*8-1:0]     req_len;
  logic [NREQ-1:0]       req_ready;
  logic [ADDRW-1:0]      rom_addr;
  logic [WIDTH-1:0]      rom_data;
  logic [NREQ-1:0]       rsp_valid;
  logic [WIDTH-1:0]      rsp_data;
  logic                  rsp_last;

  modport slave (
    input  req_valid, req_addr, req_len, rom_data,
    output req_ready, rom_addr, rsp_valid, rsp_data, rsp_last
  );

  modport master (
    output req_valid, req_addr, req_len, rom_data,
    input  req_ready, rom_addr, rsp_valid, rsp_data, rsp_last
  );
endinterface

// File: rtl/rom_arbiter.sv
// Round-robin arbiter sharing one combinational-read ROM among NREQ requesters.
// Define ROM_ARB_BURST_EN to compile in multi-beat bursts (req_len = beats-1).
//
// state | meaning
// IDLE  | grant the next requester round-robin, one single-beat access per cycle
// BURST | streaming incrementing addresses for the granted requester, no grants
module rom_arbiter #(
  parameter int NREQ  = 3,
  parameter int WIDTH = 8,
  parameter int DEPTH = 256
) (
  input logic          clk,
  input logic          rst_n,
  rom_arbiter_if.slave bus
);
  localparam int ADDRW = $clog2(DEPTH);
  localparam int PTRW  = (NREQ > 1) ? $clog2(NREQ) : 1;

`ifdef ROM_ARB_BURST_EN
  typedef enum logic {IDLE = 1'b0, BURST = 1'b1} state_t;
`else
  typedef enum logic {IDLE = 1'b0} state_t;
`endif

  state_t           state_q;
  logic [PTRW-1:0]  ptr_q;
  logic [ADDRW-1:0] rom_addr_q;
  logic [NREQ-1:0]  rsp_valid_q;
  logic [WIDTH-1:0] rsp_data_q;
  logic             rsp_last_q;

  logic [PTRW-1:0]  hi_idx, lo_idx, gnt_idx, ptr_nxt;
  logic             hi_found, lo_found, gnt_found;
  logic             handshake;
  logic [NREQ-1:0]  gnt_oh;
  logic [ADDRW-1:0] gnt_addr, rom_addr_d;

`ifdef ROM_ARB_BURST_EN
  logic [7:0]       burst_cnt_q;
  logic [ADDRW-1:0] burst_addr_q;
  logic [NREQ-1:0]  burst_sel_q;
  logic [7:0]       gnt_len;
`else
  logic             unused_len;
  assign unused_len = ^bus.req_len;
`endif

  function automatic logic [ADDRW-1:0] addr_inc(input logic [ADDRW-1:0] a);
    return (a == ADDRW'(DEPTH - 1)) ? '0 : a + ADDRW'(1);
  endfunction

  // First valid index at or above ptr wins; otherwise wrap to the lowest valid index.
  always_comb begin
    hi_found = 1'b0;
    lo_found = 1'b0;
    hi_idx   = '0;
    lo_idx   = '0;
    for (int i = NREQ - 1; i >= 0; i--) begin
      if (bus.req_valid[i]) begin
        if (i >= int'(ptr_q)) begin
          hi_found = 1'b1;
          hi_idx   = PTRW'(i);
        end else begin
          lo_found = 1'b1;
          lo_idx   = PTRW'(i);
        end
      end
    end
    gnt_found = hi_found | lo_found;
    gnt_idx   = hi_found ? hi_idx : lo_idx;
  end

  always_comb begin
    handshake = rst_n && (state_q == IDLE) && gnt_found;
    gnt_oh    = '0;
    gnt_addr  = '0;
`ifdef ROM_ARB_BURST_EN
    gnt_len   = '0;
`endif
    for (int i = 0; i < NREQ; i++) begin
      if (gnt_idx == PTRW'(i)) begin
        gnt_oh[i] = handshake;
        gnt_addr  = bus.req_addr[i*ADDRW +: ADDRW];
`ifdef ROM_ARB_BURST_EN
        gnt_len   = bus.req_len[i*8 +: 8];
`endif
      end
    end
    ptr_nxt = (gnt_idx == PTRW'(NREQ - 1)) ? '0 : gnt_idx + PTRW'(1);
  end

  // Reset forces the ROM address to zero without waiting for a clock edge.
  always_comb begin
    rom_addr_d = rom_addr_q;
    if (!rst_n)
      rom_addr_d = '0;
    else if (handshake)
      rom_addr_d = gnt_addr;
`ifdef ROM_ARB_BURST_EN
    else if (state_q == BURST)
      rom_addr_d = burst_addr_q;
`endif
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      ptr_q        <= '0;
      rom_addr_q   <= '0;
      rsp_valid_q  <= '0;
      rsp_data_q   <= '0;
      rsp_last_q   <= 1'b0;
`ifdef ROM_ARB_BURST_EN
      burst_cnt_q  <= '0;
      burst_addr_q <= '0;
      burst_sel_q  <= '0;
`endif
    end else begin
      rom_addr_q  <= rom_addr_d;
      rsp_valid_q <= '0;
      rsp_last_q  <= 1'b0;
      case (state_q)
        IDLE: begin
          if (handshake) begin
            rsp_valid_q <= gnt_oh;
            rsp_data_q  <= bus.rom_data;
            rsp_last_q  <= 1'b1;
            ptr_q       <= ptr_nxt;
`ifdef ROM_ARB_BURST_EN
            if (gnt_len != 8'd0) begin
              state_q      <= BURST;
              burst_cnt_q  <= gnt_len;
              burst_sel_q  <= gnt_oh;
              burst_addr_q <= addr_inc(gnt_addr);
              rsp_last_q   <= 1'b0;
            end
`endif
          end
        end
`ifdef ROM_ARB_BURST_EN
        // Down-counter: terminal count of 1 marks the final beat.
        BURST: begin
          rsp_valid_q  <= burst_sel_q;
          rsp_data_q   <= bus.rom_data;
          burst_addr_q <= addr_inc(burst_addr_q);
          burst_cnt_q  <= burst_cnt_q - 8'd1;
          if (burst_cnt_q == 8'd1) begin
            rsp_last_q <= 1'b1;
            state_q    <= IDLE;
          end
        end
`endif
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.req_ready = gnt_oh;
  assign bus.rom_addr  = rom_addr_d;
  assign bus.rsp_valid = rsp_valid_q;
  assign bus.rsp_data  = rsp_data_q;
  assign bus.rsp_last  = rsp_last_q;
endmodule

// File: doc/rom_arbiter.md
ROM_ARBITER -- requirements
Module: rom_arbiter

Interface
REQ-001 Parameter NREQ, 3, number of requesters sharing one ROM, range 2..8.
REQ-002 Parameter WIDTH, 8, ROM data width in bits.
REQ-003 Parameter DEPTH, 256, ROM word count; ADDRW = $clog2(DEPTH).
REQ-004 clk  in  1  single clock; all state changes on the rising edge.
REQ-005 rst_n  in  1  reset, asynchronous, active-low.
REQ-006 req_valid  in  NREQ  per-requester request strobe.
REQ-007 req_addr  in  NREQ*ADDRW  start addresses; requester i occupies bits [i*ADDRW +: ADDRW].
REQ-008 req_len  in  NREQ*8  burst length minus 1, slice [i*8 +: 8]; used only with ROM_ARB_BURST_EN.
REQ-009 req_ready  out  NREQ  grant; one-hot or zero.
REQ-010 rom_addr  out  ADDRW  address to the asynchronous (combinational-read) ROM.
REQ-011 rom_data  in  WIDTH  ROM read data, valid in the same cycle as rom_addr.
REQ-012 rsp_valid  out  NREQ  one-hot response strobe, registered.
REQ-013 rsp_data  out  WIDTH  registered read data, shared by all requesters.
REQ-014 rsp_last  out  1  registered; marks the final beat of an access.

Function
REQ-015 States SHALL be IDLE and BURST; BURST exists only with ROM_ARB_BURST_EN.
REQ-016 In IDLE, the block SHALL select requester g as the first index with req_valid set, searching from ptr upward modulo NREQ.
REQ-017 In IDLE, req_ready[g] SHALL assert combinationally in the same cycle; all other req_ready bits SHALL be 0.
REQ-018 If no req_valid bit is set, req_ready SHALL be 0 and rom_addr SHALL hold its last value.
REQ-019 On the handshake cycle, rom_addr SHALL equal req_addr[g].
REQ-020 At the clock edge ending the handshake cycle:
- rsp_data SHALL capture rom_data; read latency is exactly 1 cycle.
- rsp_valid SHALL become one-hot on bit g.
- ptr SHALL become (g+1) mod NREQ.
REQ-021 rsp_valid SHALL be 0 in any cycle that follows a non-delivery cycle; rsp_data SHALL hold its value when rsp_valid is 0.
REQ-022 Without bursts, rsp_last SHALL equal |rsp_valid; the block sustains one access per cycle.
REQ-023 Requesters SHALL be served round-robin, so no requester waits more than NREQ-1 grants.
REQ-024 req_valid deasserted on a cycle with no handshake SHALL cancel that request with no side effects.

Reset
REQ-025 While rst_n=0, regardless of clk:
- state = IDLE, ptr = 0;
- rsp_valid = 0, rsp_data = 0, rsp_last = 0;
- rom_addr = 0, burst counter = 0.
REQ-026 Asserting reset mid-burst SHALL abort the burst with no further responses; the first grant after release SHALL go to the lowest-index active requester.

Configuration
REQ-027 Macro ROM_ARB_BURST_EN compiles burst support in or out.
REQ-028 With ROM_ARB_BURST_EN, a handshake with req_len[g] = L > 0 SHALL:
- enter BURST for L further cycles;
- increment rom_addr each cycle, wrapping from DEPTH-1 to 0;
- drive req_ready = 0 throughout BURST;
- deliver L+1 consecutive rsp_valid[g] beats.
REQ-029 rsp_last SHALL assert only on the final beat; L = 0 behaves as a single access.
REQ-030 A new grant SHALL be possible in the cycle after the last BURST cycle.
REQ-031 Without ROM_ARB_BURST_EN, req_len SHALL be ignored, BURST logic SHALL be absent, and every access SHALL be single-beat.

Verification
REQ-032 Bench SHALL cover these directed scenarios (ROM word n = n XOR 8'hA5):
- Single access: req_valid=001, addr0=8'h10 -> ready=001 same cycle; next cycle rsp_valid=001, rsp_data=8'hB5, rsp_last=1.
- Fairness: all three valid continuously from reset -> grants 0,1,2,0,1,2; rsp_valid one cycle behind each grant; no gaps.
- Gap and hold: req_valid=000 for 3 cycles after an access -> rsp_valid=0, rsp_data holds the last value, ptr unchanged.
- Burst wrap (BURST_EN): requester 1, addr=8'hFE, len=3 -> data A5^FE, A5^FF, A5^00, A5^01 on bits 1; rsp_last on beat 4 only; req_ready=0 for 3 cycles.
- Reset mid-burst: rst_n low during beat 2 of a len=5 burst -> all outputs 0 immediately; after release, requester 0 granted first.
- Macro off: len=3 presented -> single beat with rsp_last=1; next grant in the following cycle.
